dot_product_ctrl: RTL
=====================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the operand-memory word-address width.
REQ-002 The block SHALL have parameter LEN_W, default 10, meaning the job-length field width, in beats of 8 fp16 pairs.
REQ-003 The block SHALL have parameter TAG_W, default 4, meaning the job-tag width.
REQ-004 The block SHALL have parameter RD_LAT, default 2, meaning the operand-memory read latency in cycles (at least 1).
REQ-005 The block SHALL have parameter STACK_LAT, default 10, meaning the cycles from stack i_last to stack o_valid (K+6 with K=4).
REQ-006 The block SHALL have parameter RES_DEPTH, default 16, meaning the result-FIFO depth (a power of 2, at least 2).
REQ-007 The block SHALL have the ports below, one per line:
  i_clk  in  1  the single clock; all logic on the rising edge
  i_reset  in  1  synchronous, active-high reset
  i_cmd_valid  in  1  command offered
  o_cmd_ready  out  1  command accepted when high together with i_cmd_valid
  i_cmd_addr  in  ADDR_W  first operand word address
  i_cmd_len  in  LEN_W  beat count
  i_cmd_tag  in  TAG_W  tag returned with the result
  o_rd_en  out  1  operand-memory read strobe (A and B share the address)
  o_rd_addr  out  ADDR_W  read address
  o_first  out  1  to stack i_first, aligned with read data
  o_last  out  1  to stack i_last, aligned with read data
  i_stk_valid  in  1  stack o_valid
  i_stk_sum  in  16  stack o_sum (fp16)
  o_res_valid  out  1  result available
  i_res_ready  in  1  result consumed
  o_res_sum  out  16  fp16 dot product
  o_res_tag  out  TAG_W  tag of that result
  o_cmd_err  out  1  one-cycle pulse when a zero-length command is accepted

Function
REQ-008 The FSM SHALL have two states, IDLE and ISSUE.
REQ-009 The block SHALL raise o_cmd_ready when the state is IDLE, or when the state is ISSUE and the current beat is the final beat, and in either case only if credit > 0.
REQ-010 On acceptance with len > 0, the block SHALL latch addr, len and tag, push the tag into the tag FIFO, decrement credit, and enter or remain in ISSUE.
REQ-011 On acceptance with len = 0, the block SHALL pulse o_cmd_err, issue no reads, consume no credit, push no tag, and produce no result.
REQ-012 In ISSUE, the block SHALL assert o_rd_en every cycle with o_rd_addr = base + beat index, for exactly len consecutive cycles.
REQ-013 Back-to-back commands SHALL incur zero bubble cycles.
REQ-014 After the final beat, the block SHALL return to IDLE unless a new command is accepted in that same cycle.
REQ-015 The block SHALL assert an internal first flag on beat 0 and an internal last flag on beat len-1; when len = 1, both SHALL be asserted on the same beat.
REQ-016 The block SHALL delay the first and last flags by exactly RD_LAT registers to form o_first and o_last, which are otherwise 0.
REQ-017 The address SHALL wrap modulo 2^ADDR_W without error.
REQ-018 On i_stk_valid, the block SHALL pop the tag FIFO and push {tag, i_stk_sum} into the result FIFO in the same cycle.
REQ-019 If i_stk_valid arrives while the tag FIFO is empty, the block SHALL drop the result.
REQ-020 The result FIFO SHALL be first-word fall-through: o_res_valid = not empty, and a pop occurs when o_res_valid and i_res_ready are both high.
REQ-021 The credit counter SHALL start at RES_DEPTH, decrement on each accept with len > 0, and increment on each result pop.
REQ-022 When an accept and a pop occur in the same cycle, the credit SHALL be unchanged.
REQ-023 Credit SHALL guarantee that neither FIFO overflows; an overflow is an assertion failure.
REQ-024 The tag FIFO depth SHALL be RES_DEPTH.
REQ-025 Results SHALL emerge in command order.

Reset
REQ-026 While i_reset is high, the block SHALL set state to IDLE, credit to RES_DEPTH, and both FIFOs to empty.
REQ-027 While i_reset is high, the block SHALL drive o_cmd_ready, o_rd_en, o_first, o_last, o_res_valid and o_cmd_err to 0, and o_rd_addr, o_res_sum and o_res_tag to 0.
REQ-028 A reset mid-job SHALL abort the job.
REQ-029 For RD_LAT+STACK_LAT cycles after i_reset falls, the block SHALL ignore i_stk_valid, to flush in-flight stack results.
REQ-030 o_cmd_ready SHALL remain 0 during that flush window.

Structure
REQ-031 A package dot_product_ctrl_pkg SHALL hold the state enum, the FP16 width constant, and the default STACK_LAT and RD_LAT values.
REQ-032 The design SHALL include one sub-module, dp_sync_fifo (parameterised width and depth, first-word fall-through), instantiated twice: once for tags and once for results.

Verification
REQ-033 Single job, len=1, addr=5, tag=3: the bench SHALL see one read at 5, o_first and o_last both high RD_LAT cycles later, and, for a stack result of 16'h3C00 (1.0), o_res_sum=16'h3C00 with o_res_tag=3.
REQ-034 Back-to-back jobs len=4 at addr 0 and len=2 at addr 100: the bench SHALL see 6 contiguous o_rd_en cycles with addresses 0,1,2,3,100,101, and o_first on beats 0 and 4, and o_last on beats 3 and 5.
REQ-035 Backpressure with i_res_ready=0 and 20 len=1 commands: the bench SHALL see exactly 16 commands accepted, then o_cmd_ready=0; one pop SHALL re-enable exactly one accept.
REQ-036 Zero-length command: the bench SHALL see an o_cmd_err pulse, no o_rd_en, and unchanged credit.
REQ-037 Wrap, with addr=1023 and len=3: the bench SHALL see addresses 1023, 0, 1.
REQ-038 Reset asserted on beat 2 of a len=8 job, with the stack still emitting i_stk_valid 5 cycles later: the bench SHALL see no o_res_valid, and o_cmd_ready returning high exactly 12 cycles after reset release.

Source files
------------

// File: rtl/dot_product_ctrl_pkg.sv
// Shared types and constants for the dot-product job controller.
package dot_product_ctrl_pkg;

  // Controller FSM: waiting for a job, or streaming operand reads for one.
  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } state_e;

  localparam int unsigned FP16_W            = 16;
  localparam int unsigned DEFAULT_RD_LAT    = 2;
  localparam int unsigned DEFAULT_STACK_LAT = 10;

  // Cycles a stack result can still be in flight after the last read strobe.
  function automatic int unsigned flush_cycles(input int unsigned rd_lat,
                                               input int unsigned stack_lat);
    return rd_lat + stack_lat;
  endfunction

endpackage

// File: rtl/dp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rdata while not empty.
module dp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Storage array; no reset needed since contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end
  end

  // Read/write pointers with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Upstream flow control must never push into a full FIFO.
  no_overflow_a : assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product job controller: turns {addr, len, tag} commands into operand read bursts,
// marks first/last beats for the accumulation stack, and pairs stack sums with job tags.
module dot_product_ctrl
  import dot_product_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RD_LAT    = DEFAULT_RD_LAT,
  parameter int unsigned STACK_LAT = DEFAULT_STACK_LAT,
  parameter int unsigned RES_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [TAG_W-1:0]  i_cmd_tag,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_first,
  output logic              o_last,
  input  logic              i_stk_valid,
  input  logic [FP16_W-1:0] i_stk_sum,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [FP16_W-1:0] o_res_sum,
  output logic [TAG_W-1:0]  o_res_tag,
  output logic              o_cmd_err
);

  localparam int unsigned CRED_W  = $clog2(RES_DEPTH + 1);
  localparam int unsigned FLUSH   = flush_cycles(RD_LAT, STACK_LAT);
  localparam int unsigned FLUSH_W = $clog2(FLUSH + 1);
  localparam int unsigned RES_W   = TAG_W + FP16_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [CRED_W-1:0]   credit_q, credit_d;
  logic [FLUSH_W-1:0]  flush_q;
  logic [RD_LAT-1:0]   first_pipe_q, last_pipe_q;

  logic                final_beat;
  logic                accept, accept_job;
  logic                first_int, last_int;
  logic                stk_take, res_pop;
  logic [TAG_W-1:0]    tag_head;
  logic                tag_empty, tag_full;
  logic [RES_W-1:0]    res_wdata, res_head;
  logic                res_empty, res_full;
  logic                flushing;

  assign flushing   = (flush_q != '0);
  assign final_beat = (state_q == StIssue) && (beat_q == len_q - LEN_W'(1));
  assign accept     = i_cmd_valid && o_cmd_ready;
  assign accept_job = accept && (i_cmd_len != '0);
  assign o_cmd_err  = accept && (i_cmd_len == '0);

  // Next-state logic and read-side outputs; everything is forced quiet while in reset.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    beat_d      = beat_q;
    o_cmd_ready = 1'b0;
    o_rd_en     = 1'b0;
    o_rd_addr   = '0;
    first_int   = 1'b0;
    last_int    = 1'b0;

    // A new job may be taken while idle or on the final beat of the current one.
    o_cmd_ready = !i_reset && !flushing && (credit_q != '0) &&
                  ((state_q == StIdle) || final_beat);

    if (!i_reset && (state_q == StIssue)) begin
      o_rd_en   = 1'b1;
      o_rd_addr = base_q + ADDR_W'(beat_q);
      first_int = (beat_q == '0);
      last_int  = final_beat;
    end

    unique case (state_q)
      StIdle: begin
        if (accept_job) begin
          state_d = StIssue;
          base_d  = i_cmd_addr;
          len_d   = i_cmd_len;
          beat_d  = '0;
        end
      end
      StIssue: begin
        if (final_beat) begin
          if (accept_job) begin
            base_d = i_cmd_addr;
            len_d  = i_cmd_len;
            beat_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and job registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  // Delay first/last so they line up with read data arriving at the stack.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
    end else begin
      first_pipe_q[0] <= first_int;
      last_pipe_q[0]  <= last_int;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        first_pipe_q[i] <= first_pipe_q[i-1];
        last_pipe_q[i]  <= last_pipe_q[i-1];
      end
    end
  end

  assign o_first = !i_reset && first_pipe_q[RD_LAT-1];
  assign o_last  = !i_reset && last_pipe_q[RD_LAT-1];

  // Post-reset flush window: stack results from aborted jobs are discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flush_q <= FLUSH_W'(FLUSH);
    end else if (flushing) begin
      flush_q <= flush_q - FLUSH_W'(1);
    end
  end

  // A stack sum without an outstanding tag has no owner and is dropped.
  assign stk_take  = !i_reset && i_stk_valid && !flushing && !tag_empty;
  assign res_wdata = {tag_head, i_stk_sum};
  assign res_pop   = o_res_valid && i_res_ready;

  assign o_res_valid = !i_reset && !res_empty;
  assign o_res_sum   = o_res_valid ? res_head[FP16_W-1:0] : '0;
  assign o_res_tag   = o_res_valid ? res_head[RES_W-1:FP16_W] : '0;

  // Credit counts free result slots not yet promised to a job in flight.
  always_comb begin
    credit_d = credit_q;
    unique case ({accept_job, res_pop})
      2'b10:   credit_d = credit_q - CRED_W'(1);
      2'b01:   credit_d = credit_q + CRED_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Credit register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      credit_q <= CRED_W'(RES_DEPTH);
    end else begin
      credit_q <= credit_d;
    end
  end

  dp_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (RES_DEPTH)
  ) u_tag_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (accept_job),
    .wdata (i_cmd_tag),
    .pop   (stk_take),
    .rdata (tag_head),
    .empty (tag_empty),
    .full  (tag_full)
  );

  dp_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (stk_take),
    .wdata (res_wdata),
    .pop   (res_pop),
    .rdata (res_head),
    .empty (res_empty),
    .full  (res_full)
  );

  credit_range_a : assert property (@(posedge i_clk) disable iff (i_reset)
                                    credit_q <= CRED_W'(RES_DEPTH));
  tag_no_overflow_a : assert property (@(posedge i_clk) disable iff (i_reset)
                                       !(accept_job && tag_full));
  res_no_overflow_a : assert property (@(posedge i_clk) disable iff (i_reset)
                                       !(stk_take && res_full));

endmodule
